usr_access_capture: RTL and testbench
=====================================

Name: usr_access_capture

Overview:
- Consumes the USR_ACCESS configuration word (DATA/DATAVALID) and turns it into a stable, decoded build timestamp on the system clock.
- Synchronises DATAVALID, debounces DATA until it is stable, and decodes the 32-bit timestamp into fields: day, month, year, hour, minute, second.
- Holds the result in registers read by the controller's status/ID register block.
- Supports a refresh request for re-capture.

Parameters:
- SYNC_STAGES, 2: flops in the usr_datavalid synchroniser (legal 2..4).
- STABLE_CYCLES, 4: consecutive identical DATA samples required before accept (legal 1..255).
- YEAR_BASE, 2000: added to the 6-bit year field to form ts_year.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- usr_data  in  32  DATA from USR_ACCESSE2; treated as quasi-static
- usr_datavalid  in  1  DATAVALID from USR_ACCESSE2; asynchronous to clk
- refresh  in  1  single-cycle pulse: discard result and re-capture
- ts_raw  out  32  accepted raw word
- ts_day  out  5  day 1..31
- ts_month  out  4  month 1..12
- ts_year  out  12  YEAR_BASE + year field
- ts_hour  out  5  hour 0..23
- ts_min  out  6  minute 0..59
- ts_sec  out  6  second 0..59
- ts_valid  out  1  level: decoded fields hold an accepted, in-range word
- ts_error  out  1  level: last accepted word failed range check
- ts_update  out  1  one-cycle pulse when ts_valid or ts_error newly asserts

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset: all outputs 0, FSM = IDLE, synchroniser cleared.
- Field map of usr_data:
  - [31:27] day
  - [26:23] month
  - [22:17] year
  - [16:12] hour
  - [11:6] min
  - [5:0] sec
- ts_year = YEAR_BASE + zero-extended year field; 12-bit result, no overflow possible.
- vsync = usr_datavalid after SYNC_STAGES flops.
- FSM states:
  - IDLE: wait for vsync=1. On entry to SETTLE, load hold_reg <= usr_data and cnt <= 1.
  - SETTLE, each cycle:
    - vsync=0 -> IDLE.
    - usr_data != hold_reg -> hold_reg <= usr_data, cnt <= 1.
    - Otherwise cnt++.
    - When cnt == STABLE_CYCLES and the data matches -> CHECK.
  - CHECK: one cycle. Latch ts_raw and all decoded fields from hold_reg. Evaluate range check, then go to DONE.
  - DONE:
    - ts_valid = pass; ts_error = not pass; ts_update pulses on the first DONE cycle.
    - Stays in DONE regardless of usr_datavalid.
- Latency with data stable: ts_update asserts SYNC_STAGES + STABLE_CYCLES + 1 clk cycles after the first clk edge that samples usr_datavalid=1.
- refresh:
  - In DONE: clear ts_valid and ts_error, go to IDLE; decoded field registers keep their last values.
  - In IDLE, SETTLE or CHECK: ignored.
  - Coincident with the entry to DONE: refresh wins; ts_update does not pulse, ts_valid stays 0.
- usr_datavalid dropping mid-SETTLE restarts acquisition; no partial result is ever published.
- cnt is 8 bits and saturates; it cannot wrap.
- rst_n asserted in any state returns everything to reset values immediately.

Optional Feature:
- Macro: USR_ACCESS_RANGE_CHECK_EN.
- Defined: pass requires all of:
  - day 1..31
  - month 1..12
  - hour <= 23
  - min <= 59
  - sec <= 59
- Undefined: pass is constant 1, ts_error is tied to 0, and no comparators are built.

Decomposition:
- Package usr_access_pkg holds:
  - the FSM state enum (IDLE, SETTLE, CHECK, DONE);
  - field LSB/width localparams for the bit map above;
  - a ts_fields_t struct (day, month, year, hour, min, sec).
- One natural sub-module: usr_access_sync, a SYNC_STAGES-deep bit synchroniser with asynchronous active-low reset to 0.

Test Plan:
- Nominal decode:
  - Stimulus: usr_data=0x79B0A7AD, usr_datavalid rises, defaults.
  - Response: ts_update at cycle 2+4+1=7; day=15, month=3, year=2024, hour=10, min=30, sec=45, ts_valid=1.
- Unstable data:
  - Stimulus: 0x79B0A7AD, then change to 0x79B0A7AE on SETTLE cycle 2.
  - Response: counter restarts; ts_update arrives 2 cycles later than nominal with sec=46.
- Range failure (macro defined):
  - Stimulus: usr_data=0x0E800000 (month 13).
  - Response: ts_error=1, ts_valid=0, single ts_update pulse.
  - With macro undefined, the same input gives ts_valid=1.
- Valid drop:
  - Stimulus: usr_datavalid deasserted for 1 cycle mid-SETTLE.
  - Response: FSM returns to IDLE; no ts_update until re-acquired after valid returns.
- Refresh:
  - Stimulus: pulse refresh in DONE, data unchanged and valid high.
  - Response: ts_valid falls the next cycle and re-asserts after STABLE_CYCLES+1 cycles; one ts_update.
- Reset mid-SETTLE:
  - Stimulus: assert rst_n=0 mid-SETTLE.
  - Response: all outputs 0 asynchronously; after release, nominal latency is observed again.

Source files
------------

// File: rtl/usr_access_pkg.sv
// Shared types for the USR_ACCESS timestamp capture: FSM states, field bit map
// of the configuration word and the decoded-field struct.
package usr_access_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DAY_LSB   = 27;
  localparam int DAY_W     = 5;
  localparam int MONTH_LSB = 23;
  localparam int MONTH_W   = 4;
  localparam int YEAR_LSB  = 17;
  localparam int YEAR_W    = 6;
  localparam int HOUR_LSB  = 12;
  localparam int HOUR_W    = 5;
  localparam int MIN_LSB   = 6;
  localparam int MIN_W     = 6;
  localparam int SEC_LSB   = 0;
  localparam int SEC_W     = 6;
  localparam int YEAR_OUT_W = 12;

  typedef struct packed {
    logic [DAY_W-1:0]      day;
    logic [MONTH_W-1:0]    month;
    logic [YEAR_OUT_W-1:0] year;
    logic [HOUR_W-1:0]     hour;
    logic [MIN_W-1:0]      min;
    logic [SEC_W-1:0]      sec;
  } ts_fields_t;

  // The 6-bit year field is an offset from year_base; 12 bits cannot overflow.
  function automatic ts_fields_t decode_ts(input logic [31:0] word,
                                           input logic [YEAR_OUT_W-1:0] year_base);
    ts_fields_t f;
    f.day   = word[DAY_LSB   +: DAY_W];
    f.month = word[MONTH_LSB +: MONTH_W];
    f.year  = year_base + {{(YEAR_OUT_W-YEAR_W){1'b0}}, word[YEAR_LSB +: YEAR_W]};
    f.hour  = word[HOUR_LSB  +: HOUR_W];
    f.min   = word[MIN_LSB   +: MIN_W];
    f.sec   = word[SEC_LSB   +: SEC_W];
    return f;
  endfunction

endpackage

// File: rtl/usr_access_sync.sv
// Multi-flop bit synchroniser for DATAVALID, cleared to 0 by asynchronous
// active-low reset.
module usr_access_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/usr_access_capture.sv
// Captures the USR_ACCESS word once DATAVALID is synchronised and DATA is stable,
// then holds the decoded build timestamp. Define USR_ACCESS_RANGE_CHECK_EN to
// range-check the fields and drive ts_error; otherwise every word is accepted.
module usr_access_capture
  import usr_access_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int YEAR_BASE     = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] usr_data,
  input  logic        usr_datavalid,
  input  logic        refresh,
  output logic [31:0] ts_raw,
  output logic [4:0]  ts_day,
  output logic [3:0]  ts_month,
  output logic [11:0] ts_year,
  output logic [4:0]  ts_hour,
  output logic [5:0]  ts_min,
  output logic [5:0]  ts_sec,
  output logic        ts_valid,
  output logic        ts_error,
  output logic        ts_update
);

  localparam logic [7:0]            STABLE_CNT  = 8'(STABLE_CYCLES);
  localparam logic [YEAR_OUT_W-1:0] YEAR_BASE_W = YEAR_OUT_W'(YEAR_BASE);

  state_t      r_state;
  state_t      w_next;
  logic        w_vsync;
  logic        w_match;
  logic        w_hold_load;
  logic        w_cnt_inc;
  logic        w_publish;
  logic        w_clear;
  logic        w_pass;
  logic [31:0] r_hold;
  logic [31:0] r_raw;
  logic [7:0]  r_cnt;
  ts_fields_t  w_dec;
  ts_fields_t  r_fields;
  logic        r_valid;
  logic        r_update;

  usr_access_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (usr_datavalid),
    .o_q  (w_vsync)
  );

  assign w_match = (usr_data == r_hold);
  assign w_dec   = decode_ts(r_hold, YEAR_BASE_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (w_vsync) w_next = SETTLE;
      SETTLE: begin
        if (!w_vsync) begin
          w_next = IDLE;
        end else if (w_match && (r_cnt >= STABLE_CNT)) begin
          w_next = CHECK;
        end
      end
      // A refresh arriving as the result would be published discards it.
      CHECK:  w_next = refresh ? IDLE : DONE;
      DONE:   if (refresh) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_hold_load = 1'b0;
    w_cnt_inc   = 1'b0;
    w_publish   = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE:   w_hold_load = w_vsync;
      SETTLE: begin
        if (w_vsync) begin
          w_hold_load = !w_match;
          w_cnt_inc   = w_match;
        end
      end
      CHECK:  w_publish = !refresh;
      DONE:   w_clear   = refresh;
      default: ;
    endcase
  end

  // Debounce: every change of DATA reloads the hold word and restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
      r_cnt  <= '0;
    end else if (w_hold_load) begin
      r_hold <= usr_data;
      r_cnt  <= 8'd1;
    end else if (w_cnt_inc && (r_cnt != 8'hFF)) begin
      r_cnt  <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raw    <= '0;
      r_fields <= '0;
      r_valid  <= 1'b0;
      r_update <= 1'b0;
    end else begin
      r_update <= w_publish;
      if (w_publish) begin
        r_raw    <= r_hold;
        r_fields <= w_dec;
        r_valid  <= w_pass;
      end else if (w_clear) begin
        r_valid  <= 1'b0;
      end
    end
  end

`ifdef USR_ACCESS_RANGE_CHECK_EN
  logic r_error;

  assign w_pass = (w_dec.day != '0) && (w_dec.month != '0) && (w_dec.month <= 4'd12) &&
                  (w_dec.hour <= 5'd23) && (w_dec.min <= 6'd59) && (w_dec.sec <= 6'd59);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_error <= 1'b0;
    end else if (w_publish) begin
      r_error <= !w_pass;
    end else if (w_clear) begin
      r_error <= 1'b0;
    end
  end

  assign ts_error = r_error;
`else
  assign w_pass   = 1'b1;
  assign ts_error = 1'b0;
`endif

  assign ts_raw    = r_raw;
  assign ts_day    = r_fields.day;
  assign ts_month  = r_fields.month;
  assign ts_year   = r_fields.year;
  assign ts_hour   = r_fields.hour;
  assign ts_min    = r_fields.min;
  assign ts_sec    = r_fields.sec;
  assign ts_valid  = r_valid;
  assign ts_update = r_update;

endmodule

// File: tb/tb_usr_access_capture.sv
// Bench for usr_access_capture: directed scenarios plus random DATA/DATAVALID/refresh,
// checked against a sliding-window acceptance model through an expected-update queue.
module tb_usr_access_capture;

  localparam int SYNC  = 2;
  localparam int N     = 4;
  localparam int YB    = 2000;
  localparam int DEPTH = 16384;
`ifdef USR_ACCESS_RANGE_CHECK_EN
  localparam bit RANGE_ON = 1'b1;
`else
  localparam bit RANGE_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] usr_data;
  logic        usr_datavalid;
  logic        refresh;
  logic [31:0] ts_raw;
  logic [4:0]  ts_day;
  logic [3:0]  ts_month;
  logic [11:0] ts_year;
  logic [4:0]  ts_hour;
  logic [5:0]  ts_min;
  logic [5:0]  ts_sec;
  logic        ts_valid;
  logic        ts_error;
  logic        ts_update;

  usr_access_capture #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(N),
    .YEAR_BASE    (YB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .usr_data     (usr_data),
    .usr_datavalid(usr_datavalid),
    .refresh      (refresh),
    .ts_raw       (ts_raw),
    .ts_day       (ts_day),
    .ts_month     (ts_month),
    .ts_year      (ts_year),
    .ts_hour      (ts_hour),
    .ts_min       (ts_min),
    .ts_sec       (ts_sec),
    .ts_valid     (ts_valid),
    .ts_error     (ts_error),
    .ts_update    (ts_update)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [37:0] ref_fields(input logic [31:0] w);
    int unsigned d, mo, y, h, mi, s;
    d  = (w >> 27) % 32;
    mo = (w >> 23) % 16;
    y  = YB + (w >> 17) % 64;
    h  = (w >> 12) % 32;
    mi = (w >> 6) % 64;
    s  = w % 64;
    return {5'(d), 4'(mo), 12'(y), 5'(h), 6'(mi), 6'(s)};
  endfunction

  function automatic bit ref_pass(input logic [31:0] w);
    int unsigned d, mo, h, mi, s;
    d  = (w >> 27) % 32;
    mo = (w >> 23) % 16;
    h  = (w >> 12) % 32;
    mi = (w >> 6) % 64;
    s  = w % 64;
    if (!RANGE_ON) return 1'b1;
    return (d >= 1) && (d <= 31) && (mo >= 1) && (mo <= 12) && (h <= 23) && (mi <= 59) && (s <= 59);
  endfunction

  logic [31:0] hist_d [DEPTH];
  logic        hist_v [DEPTH];
  int          k          = 0;  // index of the next clock edge
  int          k0         = 0;  // first edge after the latest reset release
  int          acq_start  = 0;  // earliest edge a new acquisition may begin
  bit          in_reset   = 1'b1;
  bit          m_pend     = 1'b0;
  bit          m_done     = 1'b0;
  logic [31:0] pend_word  = '0;
  logic        exp_valid  = 1'b0;
  logic        exp_error  = 1'b0;
  logic [31:0] exp_raw    = '0;
  logic [37:0] exp_flds   = '0;
  logic [63:0] exp_q[$];

  function automatic bit vs_at(input int j);
    if (j - SYNC < k0) return 1'b0;
    return hist_v[(j - SYNC) % DEPTH];
  endfunction

  // A word is accepted at edge e when the synchronised valid was high and the
  // data identical over the N+1 edges e-N..e, all inside the current acquisition.
  function automatic bit window_ok(input int e);
    if (e - N < acq_start) return 1'b0;
    for (int j = e - N; j <= e; j++) begin
      if (!vs_at(j)) return 1'b0;
      if (hist_d[j % DEPTH] !== hist_d[e % DEPTH]) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial forever begin
    @(negedge rst_n);
    in_reset  = 1'b1;
    m_pend    = 1'b0;
    m_done    = 1'b0;
    exp_valid = 1'b0;
    exp_error = 1'b0;
    exp_raw   = '0;
    exp_flds  = '0;
    exp_q.delete();
  end

  initial forever begin
    @(posedge clk);
    if (rst_n) begin
      if (in_reset) begin
        in_reset  = 1'b0;
        k0        = k;
        acq_start = k;
      end
      hist_d[k % DEPTH] = usr_data;
      hist_v[k % DEPTH] = usr_datavalid;
      if (m_pend) begin
        m_pend = 1'b0;
        if (refresh) begin
          acq_start = k + 1;
        end else begin
          exp_q.push_back({32'(k), pend_word});
          exp_valid = ref_pass(pend_word);
          exp_error = !ref_pass(pend_word);
          exp_raw   = pend_word;
          exp_flds  = ref_fields(pend_word);
          m_done    = 1'b1;
        end
      end else if (m_done) begin
        if (refresh) begin
          m_done    = 1'b0;
          exp_valid = 1'b0;
          exp_error = 1'b0;
          acq_start = k + 1;
        end
      end else if (window_ok(k)) begin
        m_pend    = 1'b1;
        pend_word = usr_data;
      end
      k++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [63:0] mon_e;

  initial forever begin
    @(negedge clk);
    check("flags", {ts_valid, ts_error}, {exp_valid, exp_error});
    check("fields", {ts_raw, ts_day, ts_month, ts_year, ts_hour, ts_min, ts_sec},
          {exp_raw, exp_flds});
    if (ts_update) begin
      if (exp_q.size() == 0) begin
        check("spurious_update", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("update_edge", mon_e[63:32], 32'(k - 1));
        check("update_word", ts_raw, mon_e[31:0]);
      end
    end else if (exp_q.size() > 0) begin
      if (int'(exp_q[0][63:32]) < k - 1) begin
        mon_e = exp_q.pop_front();
        check("missed_update", 0, 1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    usr_datavalid = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_update(input int ref_edge, output int lat);
    bit found = 1'b0;
    lat = -1;
    for (int c = 0; c < 80 && !found; c++) begin
      @(negedge clk);
      if (ts_update) begin
        found = 1'b1;
        lat = (k - 1) - ref_edge;
      end
    end
    if (!found) check("update_timeout", 0, 1);
  endtask

  function automatic logic [31:0] pick_word();
    case ($urandom_range(0, 3))
      0: return 32'h79B0A7AD;
      1: return 32'h79B0A7AE;
      2: return 32'h0E800000;
      default: return $urandom();
    endcase
  endfunction

  // ---------------- stimulus ----------------
  int ref_e;
  int lat;

  initial begin
    usr_data = '0;
    usr_datavalid = 1'b0;
    refresh = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {ts_raw, ts_day, ts_month, ts_year, ts_hour, ts_min, ts_sec,
                            ts_valid, ts_error, ts_update}, '0);
    rst_n = 1'b1;
    step();
    step();

    // nominal decode
    usr_data = 32'h79B0A7AD;
    usr_datavalid = 1'b1;
    ref_e = k;
    wait_update(ref_e, lat);
    check("nominal_latency", lat, SYNC + N + 1);
    check("nominal_fields", {ts_day, ts_month, ts_year, ts_hour, ts_min, ts_sec},
          {5'd15, 4'd3, 12'd2024, 5'd10, 6'd30, 6'd45});
    check("nominal_valid", {ts_valid, ts_error}, 2'b10);

    // refresh in DONE
    step();
    refresh = 1'b1;
    step();
    refresh = 1'b0;
    check("refresh_clears", {ts_valid, ts_error, ts_update}, 3'b000);
    check("refresh_keeps_fields", ts_sec, 6'd45);
    ref_e = k;
    wait_update(ref_e, lat);
    check("refresh_latency", lat, N + 1);

    // unstable data: change sampled on the third SETTLE edge
    do_reset();
    usr_data = 32'h79B0A7AD;
    usr_datavalid = 1'b1;
    ref_e = k;
    repeat (4) step();
    usr_data = 32'h79B0A7AE;
    wait_update(ref_e, lat);
    check("unstable_latency", lat, SYNC + N + 3);
    check("unstable_sec", ts_sec, 6'd46);

    // range failure
    do_reset();
    usr_data = 32'h0E800000;
    usr_datavalid = 1'b1;
    ref_e = k;
    wait_update(ref_e, lat);
    check("range_latency", lat, SYNC + N + 1);
    check("range_flags", {ts_valid, ts_error}, RANGE_ON ? 2'b01 : 2'b10);
    check("range_month", ts_month, 4'd13);

    // valid drop for one sample mid-SETTLE
    do_reset();
    usr_data = 32'h79B0A7AD;
    usr_datavalid = 1'b1;
    ref_e = k;
    repeat (4) step();
    usr_datavalid = 1'b0;
    step();
    usr_datavalid = 1'b1;
    wait_update(ref_e, lat);
    check("valid_drop_latency", lat, 12);

    // refresh coincident with the entry to DONE
    do_reset();
    usr_data = 32'h79B0A7AD;
    usr_datavalid = 1'b1;
    ref_e = k;
    repeat (7) step();
    refresh = 1'b1;
    step();
    refresh = 1'b0;
    check("coincident_refresh", {ts_valid, ts_update}, 2'b00);
    wait_update(ref_e, lat);
    check("coincident_relatency", lat, 13);

    // reset mid-SETTLE while old fields are still held
    step();
    refresh = 1'b1;
    step();
    refresh = 1'b0;
    step();
    step();
    #1 rst_n = 1'b0;
    #1;
    check("async_reset", {ts_raw, ts_day, ts_month, ts_year, ts_hour, ts_min, ts_sec,
                          ts_valid, ts_error, ts_update}, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ref_e = k;
    wait_update(ref_e, lat);
    check("post_reset_latency", lat, SYNC + N + 1);

    // random traffic
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 11) == 0) usr_data = pick_word();
      if ($urandom_range(0, 39) == 0) usr_datavalid = ~usr_datavalid;
      refresh = ($urandom_range(0, 24) == 0);
      step();
    end
    refresh = 1'b0;
    usr_datavalid = 1'b0;
    repeat (20) step();
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
